// File: rtl/gpio_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gpio_ctrl_pkg
// Shared constants and helpers for the GPIO control AXI4-Lite responder:
// register word indices, AXI response codes and the byte-strobe expander.
// -----------------------------------------------------------------------------
package gpio_ctrl_pkg;

  // Word index into the register file (byte address bits [4:2]).
  typedef logic [2:0] reg_idx_t;

  localparam reg_idx_t ADDR_OUT      = 3'd0;
  localparam reg_idx_t ADDR_OE       = 3'd1;
  localparam reg_idx_t ADDR_IRQ_EN   = 3'd2;
  localparam reg_idx_t ADDR_CTRL     = 3'd3;
  localparam reg_idx_t ADDR_IN       = 3'd4;
  localparam reg_idx_t ADDR_IRQ_STAT = 3'd5;

  // Indices at or above this value are unmapped.
  localparam int NUM_REGS = 6;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic reg_is_mapped(input reg_idx_t idx);
    return int'(idx) < NUM_REGS;
  endfunction

  // Expand a 4-bit byte strobe into a 32-bit bit mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/gpio_ctrl_edge_sync.sv
// -----------------------------------------------------------------------------
// gpio_ctrl_edge_sync
// Two-flop synchronizer for asynchronous GPIO pins followed by a rising-edge
// detector. The edge is reported combinationally from the synchronized value
// and one registered copy of it, so a pin change shows up on rise two clocks
// after it is first sampled.
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (all flops clear to 0)
//   din    in   WIDTH  asynchronous pin inputs
//   sync   out  WIDTH  synchronized pin values
//   rise   out  WIDTH  one-cycle pulse per pin on a 0->1 transition of sync
// -----------------------------------------------------------------------------
module gpio_ctrl_edge_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/gpio_ctrl_axil_slave.sv
// -----------------------------------------------------------------------------
// gpio_ctrl_axil_slave
// AXI4-Lite responder for the GPIO control peripheral. Terminates single-beat
// reads and writes and holds the register file that drives the GPIO outputs
// and tri-state enables, samples the GPIO inputs and raises a level interrupt
// on enabled rising input edges.
//
// Register map (word index = addr[4:2]):
//   0x00 OUT      rw   pin output values
//   0x04 OE       rw   1 = drive pin
//   0x08 IRQ_EN   rw   per-pin rising-edge interrupt enable
//   0x0C CTRL     rw   bit0 global IRQ enable, bits 31:1 scratch
//   0x10 IN       ro   synchronized pin values (writes ignored, OKAY)
//   0x14 IRQ_STAT rw1c latched rising edges
//   0x18/0x1C     unmapped, SLVERR
//
// Ports:
//   s00_axi_aclk / s00_axi_aresetn   clock, async active-low reset
//   s00_axi_aw* / w* / b*            write address, data, response channels
//   s00_axi_ar* / r*                 read address and data channels
//   gpio_i  in   GPIO_WIDTH  asynchronous pin inputs
//   gpio_o  out  GPIO_WIDTH  pin output values
//   gpio_t  out  GPIO_WIDTH  tri-state control, 1 = pin is input
//   irq     out  level interrupt, active-high
// -----------------------------------------------------------------------------
module gpio_ctrl_axil_slave
  import gpio_ctrl_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int GPIO_WIDTH         = 8
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic [GPIO_WIDTH-1:0]           gpio_i,
  output logic [GPIO_WIDTH-1:0]           gpio_o,
  output logic [GPIO_WIDTH-1:0]           gpio_t,
  output logic                            irq
);

  logic clk;
  logic rst_n;

  assign clk   = s00_axi_aclk;
  assign rst_n = s00_axi_aresetn;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // ---------------------------------------------------------------------------
  // Handshake state
  // ---------------------------------------------------------------------------
  logic        aw_ready_q;
  logic        b_valid_q;
  logic [1:0]  b_resp_q;
  logic        ar_ready_q;
  logic        r_valid_q;
  logic [1:0]  r_resp_q;
  logic [31:0] r_data_q;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [GPIO_WIDTH-1:0] out_q;
  logic [GPIO_WIDTH-1:0] oe_q;
  logic [GPIO_WIDTH-1:0] irq_en_q;
  logic [31:0]           ctrl_q;
  logic [GPIO_WIDTH-1:0] irq_stat_q;
  logic                  irq_q;

  logic [GPIO_WIDTH-1:0] in_sync;
  logic [GPIO_WIDTH-1:0] in_rise;

  reg_idx_t              wr_idx;
  reg_idx_t              rd_idx;
  logic                  wr_en;
  logic [31:0]           wr_mask;
  logic [GPIO_WIDTH-1:0] wr_mask_g;
  logic [GPIO_WIDTH-1:0] wr_data_g;
  logic [GPIO_WIDTH-1:0] stat_clr;
  logic [31:0]           rd_mux;

  assign wr_idx    = s00_axi_awaddr[4:2];
  assign rd_idx    = s00_axi_araddr[4:2];
  assign wr_mask   = strb_to_mask(s00_axi_wstrb);
  assign wr_mask_g = wr_mask[GPIO_WIDTH-1:0];
  assign wr_data_g = s00_axi_wdata[GPIO_WIDTH-1:0];

  // The write commits on the single cycle awready/wready are high; the master
  // is still presenting address and data then because it has not seen ready.
  assign wr_en = aw_ready_q;

  assign stat_clr = (wr_en && (wr_idx == ADDR_IRQ_STAT)) ? (wr_data_g & wr_mask_g)
                                                         : '0;

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge detect
  // ---------------------------------------------------------------------------
  gpio_ctrl_edge_sync #(
    .WIDTH (GPIO_WIDTH)
  ) u_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (gpio_i),
    .sync  (in_sync),
    .rise  (in_rise)
  );

  // ---------------------------------------------------------------------------
  // Write channel: accept only when both address and data are valid and no
  // response is outstanding; awready/wready pulse for exactly one cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_ready_q <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
    end else begin
      if (aw_ready_q) begin
        aw_ready_q <= 1'b0;
        b_valid_q  <= 1'b1;
        b_resp_q   <= reg_is_mapped(wr_idx) ? RESP_OKAY : RESP_SLVERR;
      end else if (s00_axi_awvalid && s00_axi_wvalid && !b_valid_q) begin
        aw_ready_q <= 1'b1;
      end

      if (b_valid_q && s00_axi_bready) begin
        b_valid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register updates. IRQ_STAT is OR'ed with new edges after the W1C clear so a
  // same-cycle edge wins over the clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      oe_q       <= '0;
      irq_en_q   <= '0;
      ctrl_q     <= '0;
      irq_stat_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_en) begin
        case (wr_idx)
          ADDR_OUT:    out_q    <= (out_q    & ~wr_mask_g) | (wr_data_g & wr_mask_g);
          ADDR_OE:     oe_q     <= (oe_q     & ~wr_mask_g) | (wr_data_g & wr_mask_g);
          ADDR_IRQ_EN: irq_en_q <= (irq_en_q & ~wr_mask_g) | (wr_data_g & wr_mask_g);
          ADDR_CTRL:   ctrl_q   <= (ctrl_q   & ~wr_mask)   | (s00_axi_wdata & wr_mask);
          default: ;
        endcase
      end

      irq_stat_q <= (irq_stat_q & ~stat_clr) | (in_rise & irq_en_q);
      irq_q      <= ctrl_q[0] & (|irq_stat_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel. Data is taken from current register state, so a write that
  // commits on the same edge is not visible to this read.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      ADDR_OUT:      rd_mux = 32'(out_q);
      ADDR_OE:       rd_mux = 32'(oe_q);
      ADDR_IRQ_EN:   rd_mux = 32'(irq_en_q);
      ADDR_CTRL:     rd_mux = ctrl_q;
      ADDR_IN:       rd_mux = 32'(in_sync);
      ADDR_IRQ_STAT: rd_mux = 32'(irq_stat_q);
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_resp_q   <= RESP_OKAY;
      r_data_q   <= '0;
    end else begin
      if (ar_ready_q) begin
        ar_ready_q <= 1'b0;
        r_valid_q  <= 1'b1;
        r_data_q   <= rd_mux;
        r_resp_q   <= reg_is_mapped(rd_idx) ? RESP_OKAY : RESP_SLVERR;
      end else if (s00_axi_arvalid && !r_valid_q) begin
        ar_ready_q <= 1'b1;
      end

      if (r_valid_q && s00_axi_rready) begin
        r_valid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s00_axi_awready = aw_ready_q;
  assign s00_axi_wready  = aw_ready_q;
  assign s00_axi_bvalid  = b_valid_q;
  assign s00_axi_bresp   = b_resp_q;
  assign s00_axi_arready = ar_ready_q;
  assign s00_axi_rvalid  = r_valid_q;
  assign s00_axi_rresp   = r_resp_q;
  assign s00_axi_rdata   = r_data_q;

  assign gpio_o = out_q;
  assign gpio_t = ~oe_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_gpio_ctrl_axil_slave.sv
// -----------------------------------------------------------------------------
// tb_gpio_ctrl_axil_slave
// Directed plus randomized bench for gpio_ctrl_axil_slave. A small register
// model (plain arithmetic on per-register variables) predicts read data,
// responses, pin outputs and the interrupt line.
// -----------------------------------------------------------------------------
module tb_gpio_ctrl_axil_slave;

  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  localparam logic [31:0] GMASK  = 32'h0000_00FF;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [7:0]  gpio_i;
  logic [7:0]  gpio_o;
  logic [7:0]  gpio_t;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_out, m_oe, m_irq_en, m_ctrl, m_stat, m_in;

  always #5 clk = ~clk;

  gpio_ctrl_axil_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (5),
    .GPIO_WIDTH         (8)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (aresetn),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .gpio_i          (gpio_i),
    .gpio_o          (gpio_o),
    .gpio_t          (gpio_t),
    .irq             (irq)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [31:0] model_val(input int idx);
    case (idx)
      0: return m_out;
      1: return m_oe;
      2: return m_irq_en;
      3: return m_ctrl;
      4: return m_in;
      5: return m_stat;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_irq();
    return m_ctrl[0] && (m_stat != 0);
  endfunction

  task automatic model_reset();
    m_out = 0; m_oe = 0; m_irq_en = 0; m_ctrl = 0; m_stat = 0; m_in = 0;
  endtask

  // Applies a write to the model and returns the response it should produce.
  task automatic model_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    logic [31:0] bm;
    int idx;
    bm   = byte_mask(strb);
    idx  = int'(addr) / 4;
    resp = (idx < 6) ? OKAY : SLVERR;
    case (idx)
      0: m_out    = ((m_out    & ~bm) | (data & bm)) & GMASK;
      1: m_oe     = ((m_oe     & ~bm) | (data & bm)) & GMASK;
      2: m_irq_en = ((m_irq_en & ~bm) | (data & bm)) & GMASK;
      3: m_ctrl   =  (m_ctrl   & ~bm) | (data & bm);
      5: m_stat   =  m_stat & ~(data & bm);
      default: ;
    endcase
  endtask

  task automatic chk_pins(input string where);
    chk({where, ":gpio_o"}, gpio_o, m_out & GMASK);
    chk({where, ":gpio_t"}, gpio_t, ~m_oe & GMASK);
    chk({where, ":irq"}, irq, model_irq());
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    chk("wr:awready", awready, 1);
    chk("wr:wready", wready, 1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr:aw_pulse", awready, 0);
    chk("wr:bvalid", bvalid, 1);
    resp = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("wr:bclear", bvalid, 0);
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    chk("rd:arready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    chk("rd:ar_pulse", arready, 0);
    chk("rd:rvalid", rvalid, 1);
    data = rdata; resp = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("rd:rclear", rvalid, 0);
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [1:0] resp, exp_resp;
    axi_write(addr, data, strb, resp);
    model_write(addr, data, strb, exp_resp);
    chk($sformatf("bresp@%02h", addr), resp, exp_resp);
    chk_pins($sformatf("after_wr@%02h", addr));
  endtask

  task automatic do_read(input logic [4:0] addr);
    logic [31:0] data;
    logic [1:0]  resp;
    int idx;
    idx = int'(addr) / 4;
    axi_read(addr, data, resp);
    chk($sformatf("rdata@%02h", addr), data, model_val(idx));
    chk($sformatf("rresp@%02h", addr), resp, (idx < 6) ? OKAY : SLVERR);
  endtask

  // Change pins, let the synchronizer and interrupt settle, then update model.
  task automatic set_gpio(input logic [7:0] v);
    logic [31:0] nv;
    @(negedge clk);
    gpio_i = v;
    repeat (5) @(negedge clk);
    nv     = {24'h0, v};
    m_stat = m_stat | (nv & ~m_in & m_irq_en);
    m_in   = nv;
    chk("gpio:irq", irq, model_irq());
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) do_read(5'(a * 4));
  endtask

  initial begin
    logic [1:0]  r0, exp_r;
    int          n;

    aresetn = 1'b0;
    awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arprot = 0; arvalid = 0; rready = 0; gpio_i = 0;
    model_reset();

    // ---- reset state
    repeat (3) @(negedge clk);
    chk("rst:awready", awready, 0);
    chk("rst:wready", wready, 0);
    chk("rst:bvalid", bvalid, 0);
    chk("rst:arready", arready, 0);
    chk("rst:rvalid", rvalid, 0);
    chk("rst:bresp", bresp, 0);
    chk("rst:rresp", rresp, 0);
    chk("rst:rdata", rdata, 0);
    chk_pins("rst");
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    read_all();

    // ---- basic write / readback
    do_write(5'h00, 32'h1, 4'hF);
    do_write(5'h04, 32'h2, 4'hF);
    do_write(5'h08, 32'h3, 4'hF);
    do_write(5'h0C, 32'h4, 4'hF);
    for (int a = 0; a < 4; a++) do_read(5'(a * 4));
    chk("basic:gpio_o", gpio_o, 8'h01);
    chk("basic:gpio_t", gpio_t, 8'hFD);

    // ---- byte strobes and held write response
    do_write(5'h0C, 32'h0, 4'hF);
    @(negedge clk);
    awaddr = 5'h0C; wdata = 32'hAABBCCDD; wstrb = 4'b0101;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    chk("hold:awready", awready, 1);
    @(negedge clk);
    model_write(5'h0C, 32'hAABBCCDD, 4'b0101, exp_r);
    chk("hold:bvalid0", bvalid, 1);
    r0 = bresp;
    chk("hold:bresp0", r0, exp_r);
    // second write presented while the first response is still pending
    awaddr = 5'h00; wdata = 32'h55; wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold:bvalid", bvalid, 1);
      chk("hold:bresp", bresp, r0);
      chk("hold:no_accept", awready, 0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("hold:bclear", bvalid, 0);
    chk("hold:not_yet", awready, 0);
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    chk("hold:second_accept", awready, 1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(5'h00, 32'h55, 4'hF, exp_r);
    chk("hold:second_bvalid", bvalid, 1);
    chk("hold:second_bresp", bresp, exp_r);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    do_read(5'h0C);
    chk("strb:ctrl", m_ctrl, 32'h00BB00DD);
    do_read(5'h00);

    // ---- unmapped addresses
    do_write(5'h18, 32'hDEADBEEF, 4'hF);
    do_write(5'h1F, 32'h12345678, 4'hF);
    do_read(5'h1C);
    do_read(5'h18);
    read_all();

    // ---- interrupt path
    do_write(5'h08, 32'h04, 4'hF);
    do_write(5'h0C, 32'h01, 4'hF);
    @(negedge clk);
    gpio_i = 8'h04;
    repeat (3) @(negedge clk);
    chk("irq:not_before_4", irq, 0);
    @(negedge clk);
    chk("irq:latency", irq, 1);
    m_stat = 32'h04; m_in = 32'h04;
    do_read(5'h14);
    do_read(5'h10);
    do_write(5'h14, 32'h04, 4'hF);
    do_read(5'h14);
    chk("irq:cleared", irq, 0);
    set_gpio(8'h0C);  // edge on pin 3, not enabled
    do_read(5'h14);
    set_gpio(8'h00);
    do_read(5'h14);

    // ---- randomized traffic
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0, 1: do_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)));
        2:    do_read(5'($urandom_range(0, 31)));
        default: set_gpio(8'($urandom));
      endcase
    end
    read_all();
    chk_pins("random_end");

    // ---- reset with a read response pending and a write mid-handshake
    set_gpio(8'h00);
    @(negedge clk);
    araddr = 5'h00; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    chk("arst:arready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    awaddr = 5'h00; wdata = 32'hFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    chk("arst:rvalid_pre", rvalid, 1);
    chk("arst:awready_pre", awready, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("arst:awready", awready, 0);
    chk("arst:wready", wready, 0);
    chk("arst:bvalid", bvalid, 0);
    chk("arst:arready0", arready, 0);
    chk("arst:rvalid", rvalid, 0);
    model_reset();
    chk_pins("arst");
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    aresetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("arst:no_bvalid", bvalid, 0);
      chk("arst:no_rvalid", rvalid, 0);
    end
    read_all();
    chk_pins("arst_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
